// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: issues in-order word fetches under a credit limit, queues returned
// instructions with their PC, and flushes on Execute redirects while discarding stale responses.
module fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] fifoInstr [DEPTH];
    logic [XLEN-1:0] fifoPc    [DEPTH];
    logic [XLEN-1:0] pcQueue   [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   pcqHead;
    logic [PW-1:0]   pcqTail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   dropCnt;

    logic            reqFire;
    logic            rspAccept;
    logic            dropRsp;
    logic            push;
    logic            pop;
    logic [SW-1:0]   credit;
    logic [XLEN-1:0] rspPc;
    logic [PW-1:0]   headNext;
    logic [CW-1:0]   countNext;
    logic [XLEN-1:0] headInstrNext;
    logic [XLEN-1:0] headPcNext;

    // Slots already promised: buffered entries plus responses that will still be kept.
    assign credit         = SW'(count) + SW'(outstanding) - SW'(dropCnt);
    assign imem_req_valid = reset && !redirect && (credit < SW'(DEPTH))
                            && (outstanding < CW'(DEPTH));
    assign imem_req_addr  = fetchPc;

    assign reqFire   = imem_req_valid && imem_req_ready;
    assign rspAccept = imem_rsp_valid && (outstanding != '0);
    assign dropRsp   = rspAccept && (redirect || (dropCnt != '0));
    assign push      = rspAccept && !dropRsp;
    assign pop       = instr_valid && !stall && !redirect;
    assign rspPc     = pcQueue[pcqHead];

    // Next head entry; when the FIFO drains to the incoming word, forward it from the write port.
    always_comb begin
        headNext      = pop ? head + PW'(1) : head;
        countNext     = count + CW'(push) - CW'(pop);
        headInstrNext = fifoInstr[headNext];
        headPcNext    = fifoPc[headNext];
        if (push && (tail == headNext)) begin
            headInstrNext = imem_rsp_data;
            headPcNext    = rspPc;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoInstr[tail] <= imem_rsp_data;
            fifoPc[tail]    <= rspPc;
        end
        if (reqFire) begin
            pcQueue[pcqTail] <= fetchPc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc       <= RESET_PC;
            head          <= '0;
            tail          <= '0;
            pcqHead       <= '0;
            pcqTail       <= '0;
            count         <= '0;
            outstanding   <= '0;
            dropCnt       <= '0;
            instr_valid   <= 1'b0;
            instr         <= '0;
            instr_pc      <= '0;
            instr_pc_plus <= '0;
        end else begin
            outstanding <= outstanding + CW'(reqFire) - CW'(rspAccept);
            if (reqFire) begin
                pcqTail <= pcqTail + PW'(1);
            end
            if (rspAccept) begin
                pcqHead <= pcqHead + PW'(1);
            end
            if (redirect) begin
                fetchPc       <= redirect_pc;
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                dropCnt       <= outstanding - CW'(rspAccept);
                instr_valid   <= 1'b0;
                instr         <= '0;
                instr_pc      <= '0;
                instr_pc_plus <= '0;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + XLEN'(1);
                end
                if (dropRsp) begin
                    dropCnt <= dropCnt - CW'(1);
                end
                if (push) begin
                    tail <= tail + PW'(1);
                end
                head          <= headNext;
                count         <= countNext;
                instr_valid   <= (countNext != '0);
                instr         <= (countNext != '0) ? headInstrNext : '0;
                instr_pc      <= (countNext != '0) ? headPcNext : '0;
                instr_pc_plus <= (countNext != '0) ? headPcNext + XLEN'(1) : '0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based model of fetch/flush behaviour plus an in-order memory with latency.
module tb_fetch_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus;

    always #5 clk = ~clk;

    fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_pc_plus(instr_pc_plus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;
    typedef struct {
        logic [31:0] pc;
        bit          stale;
        int          due;
    } req_t;

    entry_t      q[$];
    req_t        inflight[$];
    logic [31:0] mPc;
    int          cyc;
    int          lat;
    int          errors;
    int          checks;

    function automatic logic [31:0] instrOf(logic [31:0] a);
        return 32'h0000_0013 + a * 32'h0010_0080;
    endfunction

    function automatic bit expReqValid();
        int fresh;
        fresh = 0;
        foreach (inflight[i]) if (!inflight[i].stale) fresh++;
        return (reset === 1'b1) && (redirect === 1'b0) && ((q.size() + fresh) < DEPTH)
               && (inflight.size() < DEPTH);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at the falling edge once the cycle's inputs are set: drive memory, compare all outputs.
    task automatic prep();
        if (reset && inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instrOf(inflight[0].pc);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        chk("req_valid", 32'(imem_req_valid), 32'(expReqValid()));
        if (expReqValid()) chk("req_addr", imem_req_addr, mPc);
        chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
        chk("instr", instr, q.size() > 0 ? q[0].instr : 32'd0);
        chk("instr_pc", instr_pc, q.size() > 0 ? q[0].pc : 32'd0);
        chk("instr_pc_plus", instr_pc_plus, q.size() > 0 ? q[0].pc + 32'd1 : 32'd0);
        $display("cyc=%0d req=%0b addr=%h rsp=%0b redir=%0b stall=%0b valid=%0b instr=%h pc=%h",
                 cyc, imem_req_valid, imem_req_addr, imem_rsp_valid, redirect, stall,
                 instr_valid, instr, instr_pc);
    endtask

    task automatic advance();
        bit   rq;
        bit   rs;
        bit   pp;
        req_t f;
        rq = expReqValid() && imem_req_ready;
        rs = imem_rsp_valid && inflight.size() > 0;
        pp = q.size() > 0 && !stall;
        @(posedge clk);
        if (reset) begin
            if (redirect) begin
                q.delete();
                if (rs) void'(inflight.pop_front());
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                mPc = redirect_pc;
            end else begin
                if (pp) void'(q.pop_front());
                if (rs) begin
                    f = inflight.pop_front();
                    if (!f.stale) q.push_back(entry_t'{instrOf(f.pc), f.pc});
                end
                if (rq) begin
                    inflight.push_back(req_t'{mPc, 1'b0, cyc + lat});
                    mPc = mPc + 32'd1;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Holds reset for two cycles; the first cycle after release is numbered 1.
    task automatic doReset();
        reset    = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        q.delete();
        inflight.delete();
        mPc = 32'd0;
        repeat (2) begin
            prep();
            advance();
        end
        reset = 1'b1;
        cyc   = 1;
    endtask

    task automatic runUntilValid(string name, int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            prep();
            if (q.size() > 0) got = 1'b1;
            else advance();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no instruction within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; lat = 1; mPc = 0;
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_plus", instr_pc_plus, 32'd0);
        @(negedge clk);

        // Streaming from reset with single-cycle memory latency
        lat = 1;
        doReset();
        prep(); chk("t1_first_req", 32'(imem_req_valid), 32'd1);
        chk("t1_first_addr", imem_req_addr, 32'd0); advance();
        prep(); chk("t1_c2_valid", 32'(instr_valid), 32'd0); advance();
        prep(); chk("t1_c3_valid", 32'(instr_valid), 32'd1);
        chk("t1_c3_instr", instr, 32'h0000_0013);
        chk("t1_c3_pc", instr_pc, 32'd0);
        chk("t1_c3_pc_plus", instr_pc_plus, 32'd1); advance();
        prep(); chk("t1_c4_instr", instr, 32'h0010_0093);
        chk("t1_c4_pc", instr_pc, 32'd1); advance();
        repeat (6) begin prep(); advance(); end

        // Decode stalled from reset: FIFO fills, requests stop, then drain resumes fetching at 4
        doReset();
        stall = 1'b1;
        repeat (8) begin prep(); advance(); end
        stall = 1'b0;
        prep(); chk("t2_full_req", 32'(imem_req_valid), 32'd0);
        chk("t2_model_full", 32'(q.size()), 32'd4);
        chk("t2_head_pc", instr_pc, 32'd0); advance();
        prep(); chk("t2_resume_req", 32'(imem_req_valid), 32'd1);
        chk("t2_resume_addr", imem_req_addr, 32'd4);
        chk("t2_second_pc", instr_pc, 32'd1); advance();
        repeat (6) begin prep(); advance(); end

        // Latency 3, redirect with two requests in flight
        lat = 3;
        doReset();
        prep(); advance();
        prep(); advance();
        redirect = 1'b1; redirect_pc = 32'h40;
        prep(); chk("t3_model_inflight", 32'(inflight.size()), 32'd2);
        chk("t3_no_req", 32'(imem_req_valid), 32'd0); advance();
        redirect = 1'b0;
        prep(); chk("t3_req_addr", imem_req_addr, 32'h40); advance();
        runUntilValid("t3_wait", 20);
        chk("t3_cycle", 32'(cyc), 32'd8);
        chk("t3_pc", instr_pc, 32'h40);
        chk("t3_pc_plus", instr_pc_plus, 32'h41);
        chk("t3_instr", instr, 32'h0400_2013); advance();
        repeat (4) begin prep(); advance(); end

        // Redirect colliding with a response and a pop
        lat = 1;
        doReset();
        repeat (4) begin prep(); advance(); end
        redirect = 1'b1; redirect_pc = 32'h100;
        prep(); chk("t4_popping", 32'(instr_valid), 32'd1); advance();
        redirect = 1'b0;
        prep(); chk("t4_flushed", 32'(instr_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h100); advance();
        runUntilValid("t4_wait", 10);
        chk("t4_pc", instr_pc, 32'h100); advance();

        // Fetch PC wrap-around
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        prep(); advance();
        redirect = 1'b0;
        runUntilValid("t5_wait", 10);
        chk("t5_pc", instr_pc, 32'hFFFF_FFFF);
        chk("t5_pc_plus", instr_pc_plus, 32'h0000_0000);
        chk("t5_instr", instr, 32'hFFEF_FF93); advance();
        prep(); chk("t5_wrap_pc", instr_pc, 32'h0000_0000);
        chk("t5_wrap_pc_plus", instr_pc_plus, 32'h0000_0001); advance();

        // Asynchronous reset with entries buffered and requests in flight
        lat = 2;
        stall = 1'b1;
        repeat (6) begin prep(); advance(); end
        chk("t6_buffered", 32'(instr_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'(instr_valid), 32'd0);
        chk("t6_async_req", 32'(imem_req_valid), 32'd0);
        chk("t6_async_instr", instr, 32'd0);
        @(negedge clk);
        doReset();
        prep(); chk("t6_restart_addr", imem_req_addr, 32'd0);
        chk("t6_restart_req", 32'(imem_req_valid), 32'd1); advance();
        runUntilValid("t6_wait", 10);
        chk("t6_first_pc", instr_pc, 32'd0); advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
